// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit multiplexed 7-segment driver with frame-aligned commit
// Optional decimal-point support is enabled by defining SEG7_DP_EN.
module seg7_scan_driver #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int DIGIT_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value_in,
  input  logic [7:0]  blank_in,
`ifdef SEG7_DP_EN
  input  logic [7:0]  dp_in,
  output logic        dp,
`endif
  output logic [7:0]  digits,
  output logic [6:0]  segments,
  output logic        frame_start,
  output logic        load_pending
);

  localparam int TICK_DIV = CLK_HZ / DIGIT_HZ;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_val_q, shadow_val_d, pend_val_q, pend_val_d;
  logic [7:0]    shadow_blank_q, shadow_blank_d, pend_blank_q, pend_blank_d;
  logic          load_pending_q, load_pending_d;
  logic [7:0]    digits_q, digits_d;
  logic [6:0]    segments_q, segments_d;
  logic          frame_start_q, frame_start_d;
  logic          tick, frame;
`ifdef SEG7_DP_EN
  logic [7:0]    shadow_dp_q, shadow_dp_d, pend_dp_q, pend_dp_d;
  logic          dp_q, dp_d;
`endif

  always_comb begin
    tick           = (presc_q == TICK_LAST);
    frame          = tick && (idx_q == 3'd7);
    presc_d        = tick ? '0 : presc_q + 1'b1;
    idx_d          = tick ? idx_q + 3'd1 : idx_q;
    frame_start_d  = frame;
    shadow_val_d   = shadow_val_q;
    shadow_blank_d = shadow_blank_q;
    pend_val_d     = pend_val_q;
    pend_blank_d   = pend_blank_q;
    load_pending_d = load_pending_q;
`ifdef SEG7_DP_EN
    shadow_dp_d    = shadow_dp_q;
    pend_dp_d      = pend_dp_q;
`endif
    // A load landing on the boundary wins over anything already pending.
    if (frame && load) begin
      shadow_val_d   = value_in;
      shadow_blank_d = blank_in;
      load_pending_d = 1'b0;
`ifdef SEG7_DP_EN
      shadow_dp_d    = dp_in;
`endif
    end else if (frame && load_pending_q) begin
      shadow_val_d   = pend_val_q;
      shadow_blank_d = pend_blank_q;
      load_pending_d = 1'b0;
`ifdef SEG7_DP_EN
      shadow_dp_d    = pend_dp_q;
`endif
    end else if (load) begin
      pend_val_d     = value_in;
      pend_blank_d   = blank_in;
      load_pending_d = 1'b1;
`ifdef SEG7_DP_EN
      pend_dp_d      = dp_in;
`endif
    end

    if (shadow_blank_q[idx_q]) begin
      digits_d   = 8'hFF;
      segments_d = 7'h7F;
    end else begin
      digits_d   = ~(8'd1 << idx_q);
      segments_d = seg_decode(shadow_val_q[{idx_q, 2'b00} +: 4]);
    end
`ifdef SEG7_DP_EN
    dp_d = shadow_blank_q[idx_q] ? 1'b1 : ~shadow_dp_q[idx_q];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q        <= '0;
      idx_q          <= 3'd0;
      shadow_val_q   <= 32'd0;
      shadow_blank_q <= 8'hFF;
      pend_val_q     <= 32'd0;
      pend_blank_q   <= 8'd0;
      load_pending_q <= 1'b0;
      digits_q       <= 8'hFF;
      segments_q     <= 7'h7F;
      frame_start_q  <= 1'b0;
`ifdef SEG7_DP_EN
      shadow_dp_q    <= 8'd0;
      pend_dp_q      <= 8'd0;
      dp_q           <= 1'b1;
`endif
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      shadow_val_q   <= shadow_val_d;
      shadow_blank_q <= shadow_blank_d;
      pend_val_q     <= pend_val_d;
      pend_blank_q   <= pend_blank_d;
      load_pending_q <= load_pending_d;
      digits_q       <= digits_d;
      segments_q     <= segments_d;
      frame_start_q  <= frame_start_d;
`ifdef SEG7_DP_EN
      shadow_dp_q    <= shadow_dp_d;
      pend_dp_q      <= pend_dp_d;
      dp_q           <= dp_d;
`endif
    end
  end

  assign digits       = digits_q;
  assign segments     = segments_q;
  assign frame_start  = frame_start_q;
  assign load_pending = load_pending_q;
`ifdef SEG7_DP_EN
  assign dp           = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (TICK_DIV=8)
module tb_seg7_scan_driver;

  localparam int TD    = 8;
  localparam int FRAME = TD * 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] value_in = 32'd0;
  logic [7:0]  blank_in = 8'd0;
  logic [7:0]  digits;
  logic [6:0]  segments;
  logic        frame_start, load_pending;
`ifdef SEG7_DP_EN
  logic [7:0]  dp_in = 8'd0;
  logic        dp;
`endif

  seg7_scan_driver #(.CLK_HZ(80), .DIGIT_HZ(10)) dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .blank_in(blank_in),
`ifdef SEG7_DP_EN
    .dp_in(dp_in), .dp(dp),
`endif
    .digits(digits), .segments(segments), .frame_start(frame_start),
    .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dg;
    logic [6:0] sg;
    logic       fs;
    logic       lp;
    logic       dpv;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model state: time is the count of clock edges since reset release.
  int          n = 0;
  logic [31:0] sh_val = 32'd0, pn_val = 32'd0;
  logic [7:0]  sh_blank = 8'hFF, pn_blank = 8'd0;
  logic [7:0]  sh_dp = 8'd0, pn_dp = 8'd0;
  bit          pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  initial begin : model
    int   slot;
    bit   boundary;
    exp_t e;
    logic [7:0] cur_dp;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        n = 0; sh_val = 0; sh_blank = 8'hFF; pn_val = 0; pn_blank = 0;
        sh_dp = 0; pn_dp = 0; pend = 0;
        exp_q.delete();
      end else begin
        slot     = (n / TD) % 8;
        boundary = (n % FRAME) == FRAME - 1;
`ifdef SEG7_DP_EN
        cur_dp = dp_in;
`else
        cur_dp = 8'd0;
`endif
        if (sh_blank[slot]) begin
          e.dg = 8'hFF; e.sg = 7'h7F; e.dpv = 1'b1;
        end else begin
          e.dg  = 8'hFF ^ (8'(1) << slot);
          e.sg  = seg_tab[(sh_val >> (4 * slot)) & 32'hF];
          e.dpv = ~sh_dp[slot];
        end
        e.fs = boundary;
        if (boundary && load) begin
          sh_val = value_in; sh_blank = blank_in; sh_dp = cur_dp; pend = 0;
        end else if (boundary && pend) begin
          sh_val = pn_val; sh_blank = pn_blank; sh_dp = pn_dp; pend = 0;
        end else if (load) begin
          pn_val = value_in; pn_blank = blank_in; pn_dp = cur_dp; pend = 1;
        end
        e.lp = pend;
        exp_q.push_back(e);
        n++;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        chk("one_hot_digits", 32'($countones(~digits) <= 1), 32'd1);
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("digits", 32'(digits), 32'(e.dg));
          chk("segments", 32'(segments), 32'(e.sg));
          chk("frame_start", 32'(frame_start), 32'(e.fs));
          chk("load_pending", 32'(load_pending), 32'(e.lp));
`ifdef SEG7_DP_EN
          chk("dp", 32'(dp), 32'(e.dpv));
`endif
        end
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse(input logic [31:0] v, input logic [7:0] b);
    load = 1'b1; value_in = v; blank_in = b;
`ifdef SEG7_DP_EN
    dp_in = 8'($urandom);
`endif
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_boundary();
    int k;
    k = 0;
    while ((n % FRAME) != FRAME - 1 && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    chk("boundary_timeout", 32'((n % FRAME) == FRAME - 1), 32'd1);
  endtask

  initial begin : stim
    idle(3);
    rst = 1'b0;
    idle(200);

    pulse(32'h0123_4567, 8'h00);
    idle(150);

    wait_boundary();
    idle(3);
    pulse(32'h1111_1111, 8'h00);
    idle(10);
    pulse(32'hAAAA_AAAA, 8'h00);
    idle(140);

    wait_boundary();
    pulse(32'hFFFF_FFFF, 8'h00);
    idle(140);

    pulse(32'h8888_8888, 8'b1010_1010);
    idle(140);

    repeat (25) begin
      if ($urandom_range(0, 3) == 0) wait_boundary();
      else idle($urandom_range(1, 90));
      pulse($urandom, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom));
    end
    idle(140);

    wait_boundary();
    idle(5);
    pulse(32'h5A5A_5A5A, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("rst_digits", 32'(digits), 32'hFF);
    chk("rst_segments", 32'(segments), 32'h7F);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_load_pending", 32'(load_pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
